fetch_arb: RTL and testbench

Arbiter and sequencer for the single line-fetch engine shared by the cache read controller (`rd_`) and write controller (`wr_`). It accepts fetch/write-back requests from both controllers and grants one at a time with round-robin priority. It forwards the winner's command to the fetch engine and returns a completion pulse to the owning requester. Only one fetch transaction is outstanding at any time.

---
 rtl/fetch_arb.sv | 144 ++++++++++++++
 tb/tb_fetch_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_arb.sv
// Round-robin arbiter that shares one line-fetch engine between the cache read
// and write controllers, keeping a single fetch transaction outstanding.
module fetch_arb #(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned list_depth     = 4,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                rd_fetch_req,
  input  logic [1:0]                                          rd_fetch_cmd,
  input  logic [((list_depth > 1) ? $clog2(list_depth) : 1)-1:0] rd_fetch_tag,
  input  logic [addr_width-1:0]                               rd_fetch_addr,
  input  logic [addr_width-1:0]                               rd_fetch_addr_pre,
  output logic                                                rd_fetch_gnt,
  output logic                                                rd_fetch_done,
  input  logic                                                wr_fetch_req,
  input  logic [1:0]                                          wr_fetch_cmd,
  input  logic [((list_depth > 1) ? $clog2(list_depth) : 1)-1:0] wr_fetch_tag,
  input  logic [addr_width-1:0]                               wr_fetch_addr,
  input  logic [addr_width-1:0]                               wr_fetch_addr_pre,
  output logic                                                wr_fetch_gnt,
  output logic                                                wr_fetch_done,
  output logic                                                fe_req,
  output logic [1:0]                                          fe_cmd,
  output logic [((list_depth > 1) ? $clog2(list_depth) : 1)-1:0] fe_tag,
  output logic [addr_width-1:0]                               fe_addr,
  output logic [addr_width-1:0]                               fe_addr_pre,
  input  logic                                                fe_gnt,
  input  logic                                                fe_done,
  output logic                                                arb_busy,
  output logic                                                arb_owner,
  output logic                                                err_timeout
);

  localparam int unsigned TW = (list_depth > 1) ? $clog2(list_depth) : 1;
  localparam int unsigned CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] WDOG_MAX = CW'(timeout_cycles);
  localparam logic [1:0] CMD_FETCH = 2'b01;
  localparam logic [1:0] CMD_WB    = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_owner_q;
  logic                  owner_q;
  logic [1:0]            cmd_q;
  logic [TW-1:0]         tag_q;
  logic [addr_width-1:0] addr_q;
  logic [addr_width-1:0] addr_pre_q;
  logic [CW-1:0]         wdog_q;
  logic                  err_q;

  logic       grant;
  logic       grant_wr;
  logic [1:0] sel_cmd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, grant selection and completion pulses
  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    grant_wr      = 1'b0;
    sel_cmd       = 2'b00;
    rd_fetch_gnt  = 1'b0;
    wr_fetch_gnt  = 1'b0;
    rd_fetch_done = 1'b0;
    wr_fetch_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (rd_fetch_req || wr_fetch_req)) begin
          grant = 1'b1;
          // On a tie the requester that did not own the engine last time wins
          grant_wr     = wr_fetch_req && (!rd_fetch_req || !last_owner_q);
          rd_fetch_gnt = !grant_wr;
          wr_fetch_gnt = grant_wr;
          sel_cmd      = grant_wr ? wr_fetch_cmd : rd_fetch_cmd;
          state_d      = (sel_cmd == CMD_FETCH || sel_cmd == CMD_WB) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (fe_gnt) state_d = fe_done ? RESP : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fe_done) state_d = RESP;
      end
      RESP: begin
        rd_fetch_done = !owner_q;
        wr_fetch_done = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner field capture on grant and round-robin history update on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      cmd_q        <= 2'b00;
      tag_q        <= '0;
      addr_q       <= '0;
      addr_pre_q   <= '0;
    end else begin
      if (grant) begin
        owner_q    <= grant_wr;
        cmd_q      <= sel_cmd;
        tag_q      <= grant_wr ? wr_fetch_tag      : rd_fetch_tag;
        addr_q     <= grant_wr ? wr_fetch_addr     : rd_fetch_addr;
        addr_pre_q <= grant_wr ? wr_fetch_addr_pre : rd_fetch_addr_pre;
      end
      if (state_q == RESP) last_owner_q <= owner_q;
    end
  end

  // Watchdog: counts WAIT_DONE cycles, saturates and flags a sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == IDLE && state_d == ISSUE) begin
      wdog_q <= '0;
    end else if (state_q == WAIT_DONE && wdog_q != WDOG_MAX) begin
      wdog_q <= wdog_q + CW'(1);
      if (wdog_q == WDOG_MAX - CW'(1)) err_q <= 1'b1;
    end
  end

  assign fe_req      = (state_q == ISSUE);
  assign fe_cmd      = fe_req ? cmd_q      : 2'b00;
  assign fe_tag      = fe_req ? tag_q      : '0;
  assign fe_addr     = fe_req ? addr_q     : '0;
  assign fe_addr_pre = fe_req ? addr_pre_q : '0;
  assign arb_busy    = (state_q != IDLE);
  assign arb_owner   = owner_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fetch_arb.sv
// Directed bench for fetch_arb: arbitration, fetch handshake, null commands,
// watchdog timeout and mid-transaction reset.
module tb_fetch_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_fetch_req, wr_fetch_req;
  logic [1:0]    rd_fetch_cmd, wr_fetch_cmd;
  logic [TW-1:0] rd_fetch_tag, wr_fetch_tag;
  logic [AW-1:0] rd_fetch_addr, rd_fetch_addr_pre, wr_fetch_addr, wr_fetch_addr_pre;
  logic          rd_fetch_gnt, rd_fetch_done, wr_fetch_gnt, wr_fetch_done;
  logic          fe_req, fe_gnt, fe_done;
  logic [1:0]    fe_cmd;
  logic [TW-1:0] fe_tag;
  logic [AW-1:0] fe_addr, fe_addr_pre;
  logic          arb_busy, arb_owner, err_timeout;

  int passed = 0;
  int total  = 0;

  fetch_arb #(.addr_width(AW), .list_depth(4), .timeout_cycles(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_fetch_req(rd_fetch_req), .rd_fetch_cmd(rd_fetch_cmd), .rd_fetch_tag(rd_fetch_tag),
    .rd_fetch_addr(rd_fetch_addr), .rd_fetch_addr_pre(rd_fetch_addr_pre),
    .rd_fetch_gnt(rd_fetch_gnt), .rd_fetch_done(rd_fetch_done),
    .wr_fetch_req(wr_fetch_req), .wr_fetch_cmd(wr_fetch_cmd), .wr_fetch_tag(wr_fetch_tag),
    .wr_fetch_addr(wr_fetch_addr), .wr_fetch_addr_pre(wr_fetch_addr_pre),
    .wr_fetch_gnt(wr_fetch_gnt), .wr_fetch_done(wr_fetch_done),
    .fe_req(fe_req), .fe_cmd(fe_cmd), .fe_tag(fe_tag), .fe_addr(fe_addr),
    .fe_addr_pre(fe_addr_pre), .fe_gnt(fe_gnt), .fe_done(fe_done),
    .arb_busy(arb_busy), .arb_owner(arb_owner), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_fetch_req = 1'b0; rd_fetch_cmd = 2'b00; rd_fetch_tag = '0;
    rd_fetch_addr = '0; rd_fetch_addr_pre = '0;
    wr_fetch_req = 1'b0; wr_fetch_cmd = 2'b00; wr_fetch_tag = '0;
    wr_fetch_addr = '0; wr_fetch_addr_pre = '0;
    fe_gnt = 1'b0; fe_done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_fe_req", 64'(fe_req), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_owner", 64'(arb_owner), 64'd0);
    rst_n = 1'b1;

    // Single rd fetch: gnt same cycle, fe_gnt one cycle late, fe_done 3 cycles later
    tick();
    rd_fetch_req = 1'b1; rd_fetch_cmd = 2'b01; rd_fetch_tag = 2'd2;
    rd_fetch_addr = 32'h100; rd_fetch_addr_pre = 32'h40;
    #1;
    chk("t1_rd_gnt", 64'(rd_fetch_gnt), 64'd1);
    chk("t1_wr_gnt", 64'(wr_fetch_gnt), 64'd0);
    chk("t1_fe_req_idle", 64'(fe_req), 64'd0);
    tick(); rd_fetch_req = 1'b0; #1;
    chk("t1_fe_req", 64'(fe_req), 64'd1);
    chk("t1_fe_cmd", 64'(fe_cmd), 64'd1);
    chk("t1_fe_tag", 64'(fe_tag), 64'd2);
    chk("t1_fe_addr", 64'(fe_addr), 64'h100);
    chk("t1_fe_addr_pre", 64'(fe_addr_pre), 64'h40);
    chk("t1_owner", 64'(arb_owner), 64'd0);
    chk("t1_rd_gnt_off", 64'(rd_fetch_gnt), 64'd0);
    tick(); fe_gnt = 1'b1; #1;
    chk("t1_fe_req_hold", 64'(fe_req), 64'd1);
    chk("t1_fe_addr_hold", 64'(fe_addr), 64'h100);
    tick(); fe_gnt = 1'b0; #1;
    chk("t1_wait_fe_req", 64'(fe_req), 64'd0);
    chk("t1_wait_fe_addr", 64'(fe_addr), 64'd0);
    chk("t1_wait_busy", 64'(arb_busy), 64'd1);
    tick(); tick(); fe_done = 1'b1; #1;
    chk("t1_done_early", 64'(rd_fetch_done), 64'd0);
    tick(); fe_done = 1'b0; #1;
    chk("t1_rd_done", 64'(rd_fetch_done), 64'd1);
    chk("t1_wr_done", 64'(wr_fetch_done), 64'd0);
    tick();
    chk("t1_done_once", 64'(rd_fetch_done), 64'd0);
    chk("t1_idle", 64'(arb_busy), 64'd0);
    chk("t1_no_err", 64'(err_timeout), 64'd0);

    // Fresh reset, then tie: rd first, wr pending, same-cycle fe_gnt/fe_done
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rd_fetch_req = 1'b1; rd_fetch_cmd = 2'b01; rd_fetch_tag = 2'd1; rd_fetch_addr = 32'h200;
    wr_fetch_req = 1'b1; wr_fetch_cmd = 2'b01; wr_fetch_tag = 2'd3; wr_fetch_addr = 32'h300;
    #1;
    chk("t2_tie_rd_gnt", 64'(rd_fetch_gnt), 64'd1);
    chk("t2_tie_wr_gnt", 64'(wr_fetch_gnt), 64'd0);
    tick(); rd_fetch_req = 1'b0; fe_gnt = 1'b1; fe_done = 1'b1; #1;
    chk("t2_fe_addr_rd", 64'(fe_addr), 64'h200);
    chk("t2_wr_pending", 64'(wr_fetch_gnt), 64'd0);
    tick(); fe_gnt = 1'b0; fe_done = 1'b0; #1;
    chk("t2_rd_done_fast", 64'(rd_fetch_done), 64'd1);
    chk("t2_wr_gnt_resp", 64'(wr_fetch_gnt), 64'd0);
    tick();
    chk("t2_wr_gnt", 64'(wr_fetch_gnt), 64'd1);
    chk("t2_rd_gnt_off", 64'(rd_fetch_gnt), 64'd0);
    tick(); wr_fetch_req = 1'b0; fe_gnt = 1'b1; fe_done = 1'b1; #1;
    chk("t2_fe_tag_wr", 64'(fe_tag), 64'd3);
    chk("t2_fe_addr_wr", 64'(fe_addr), 64'h300);
    chk("t2_owner_wr", 64'(arb_owner), 64'd1);
    tick(); fe_gnt = 1'b0; fe_done = 1'b0; #1;
    chk("t2_wr_done", 64'(wr_fetch_done), 64'd1);
    chk("t2_rd_done_off", 64'(rd_fetch_done), 64'd0);
    tick();

    // Four null-command ties alternate rd, wr, rd, wr and never reach the engine
    for (int i = 0; i < 4; i++) begin
      rd_fetch_req = 1'b1; rd_fetch_cmd = 2'b00;
      wr_fetch_req = 1'b1; wr_fetch_cmd = (i == 1) ? 2'b11 : 2'b00;
      #1;
      chk($sformatf("tie%0d_rd_gnt", i), 64'(rd_fetch_gnt), 64'((i % 2) == 0));
      chk($sformatf("tie%0d_wr_gnt", i), 64'(wr_fetch_gnt), 64'((i % 2) == 1));
      tick();
      if ((i % 2) == 0) rd_fetch_req = 1'b0; else wr_fetch_req = 1'b0;
      #1;
      chk($sformatf("tie%0d_fe_req", i), 64'(fe_req), 64'd0);
      chk($sformatf("tie%0d_rd_done", i), 64'(rd_fetch_done), 64'((i % 2) == 0));
      chk($sformatf("tie%0d_wr_done", i), 64'(wr_fetch_done), 64'((i % 2) == 1));
      tick();
      chk($sformatf("tie%0d_idle", i), 64'(arb_busy), 64'd0);
    end
    rd_fetch_req = 1'b0; wr_fetch_req = 1'b0;

    // Watchdog: write-back fetch with fe_done withheld 12 WAIT_DONE cycles
    rd_fetch_req = 1'b1; rd_fetch_cmd = 2'b10; rd_fetch_tag = 2'd0;
    rd_fetch_addr = 32'h500; rd_fetch_addr_pre = 32'h480;
    #1;
    chk("t5_rd_gnt", 64'(rd_fetch_gnt), 64'd1);
    tick(); rd_fetch_req = 1'b0; fe_gnt = 1'b1; #1;
    chk("t5_fe_cmd", 64'(fe_cmd), 64'd2);
    chk("t5_fe_addr_pre", 64'(fe_addr_pre), 64'h480);
    tick(); fe_gnt = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk($sformatf("t5_err_wait%0d", k), 64'(err_timeout), 64'(k >= 9));
      tick();
    end
    fe_done = 1'b1; #1;
    chk("t5_still_waiting", 64'(arb_busy), 64'd1);
    tick(); fe_done = 1'b0; #1;
    chk("t5_rd_done", 64'(rd_fetch_done), 64'd1);
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);
    tick();
    chk("t5_err_idle", 64'(err_timeout), 64'd1);
    chk("t5_idle", 64'(arb_busy), 64'd0);

    // Reset during WAIT_DONE abandons the transaction
    wr_fetch_req = 1'b1; wr_fetch_cmd = 2'b01; wr_fetch_tag = 2'd1; wr_fetch_addr = 32'h600;
    #1;
    chk("t6_wr_gnt", 64'(wr_fetch_gnt), 64'd1);
    tick(); wr_fetch_req = 1'b0; fe_gnt = 1'b1;
    tick(); fe_gnt = 1'b0; #1;
    chk("t6_in_wait", 64'(arb_busy), 64'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_busy", 64'(arb_busy), 64'd0);
    chk("t6_rst_fe_req", 64'(fe_req), 64'd0);
    chk("t6_rst_fe_addr", 64'(fe_addr), 64'd0);
    chk("t6_rst_owner", 64'(arb_owner), 64'd0);
    chk("t6_rst_err", 64'(err_timeout), 64'd0);
    tick(); rst_n = 1'b1; fe_done = 1'b1; #1;
    chk("t6_no_wr_done", 64'(wr_fetch_done), 64'd0);
    tick(); fe_done = 1'b0; #1;
    chk("t6_no_wr_done2", 64'(wr_fetch_done), 64'd0);
    chk("t6_idle", 64'(arb_busy), 64'd0);
    rd_fetch_req = 1'b1; rd_fetch_cmd = 2'b01; rd_fetch_tag = 2'd3; rd_fetch_addr = 32'h700;
    #1;
    chk("t6_rd_gnt", 64'(rd_fetch_gnt), 64'd1);
    tick(); rd_fetch_req = 1'b0; fe_gnt = 1'b1; fe_done = 1'b1; #1;
    chk("t6_fe_addr", 64'(fe_addr), 64'h700);
    chk("t6_fe_req", 64'(fe_req), 64'd1);
    tick(); fe_gnt = 1'b0; fe_done = 1'b0; #1;
    chk("t6_rd_done", 64'(rd_fetch_done), 64'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
